// File: rtl/bsg_buf_ctrl_pipe.sv
// Registered fanout of one control bit to width_p outputs through a flop tree
// in which no flop drives more than fanout_p loads. Includes a stretcher, a hold enable and a primed flag.
module bsg_buf_ctrl_pipe #(
  parameter int width_p     = 64,
  parameter int fanout_p    = 8,
  parameter int stretch_p   = 0,
  parameter bit reset_val_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               i,
  output logic [width_p-1:0] o,
  output logic               v_o
);

  function automatic int calc_levels(input int w, input int f);
    int l;
    int span;
    l    = 0;
    span = 1;
    while (span < w) begin
      span = span * f;
      l    = l + 1;
    end
    return l;
  endfunction

  function automatic int level_size(input int w, input int f, input int l, input int j);
    int d;
    d = 1;
    for (int m = 0; m < l - j; m++) d = d * f;
    return (w + d - 1) / d;
  endfunction

  function automatic int level_off(input int w, input int f, input int l, input int j);
    int off;
    off = 0;
    for (int m = 0; m < j; m++) off = off + level_size(w, f, l, m);
    return off;
  endfunction

  // Maps a flat flop index to the flat index of the flop that feeds it.
  function automatic int parent_of(input int w, input int f, input int l, input int b);
    int p;
    int off;
    int n;
    p = 0;
    for (int j = 1; j <= l; j++) begin
      off = level_off(w, f, l, j);
      n   = level_size(w, f, l, j);
      if (b >= off && b < off + n) p = level_off(w, f, l, j - 1) + (b - off) / f;
    end
    return p;
  endfunction

  localparam int levels_lp   = calc_levels(width_p, fanout_p);
  localparam int out_base_lp = level_off(width_p, fanout_p, levels_lp, levels_lp);
  localparam int flops_lp    = out_base_lp + width_p;
  localparam int prime_w_lp  = $clog2(levels_lp + 2);
  localparam logic [prime_w_lp-1:0] prime_max_lp = prime_w_lp'(levels_lp + 1);

  logic                  s;
  logic [flops_lp-1:0]   tree_r;
  logic [flops_lp-1:0]   tree_n;
  logic [prime_w_lp-1:0] prime_r;

  if (stretch_p > 0) begin : g_stretch
    localparam int cnt_w_lp = $clog2(stretch_p + 1);
    logic [cnt_w_lp-1:0] cnt_r;

    // A new high on i always reloads, so closely spaced pulses merge.
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        cnt_r <= '0;
      end else if (en_i) begin
        if (i)                cnt_r <= cnt_w_lp'(stretch_p);
        else if (cnt_r != '0) cnt_r <= cnt_r - cnt_w_lp'(1);
      end
    end

    assign s = i | (cnt_r != '0);
  end else begin : g_no_stretch
    assign s = i;
  end

  // Flat layout: level 0 at bit 0, each level follows the previous one, last level drives o.
  assign tree_n[0] = s;
  for (genvar b = 1; b < flops_lp; b++) begin : g_link
    localparam int par_lp = parent_of(width_p, fanout_p, levels_lp, b);
    assign tree_n[b] = tree_r[par_lp];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)  tree_r <= {flops_lp{reset_val_p}};
    else if (en_i)   tree_r <= tree_n;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)                            prime_r <= '0;
    else if (en_i && (prime_r != prime_max_lp)) prime_r <= prime_r + prime_w_lp'(1);
  end

  assign o   = tree_r[out_base_lp +: width_p];
  assign v_o = (prime_r == prime_max_lp);

endmodule
